cache_nway_controller: RTL and testbench
========================================

# cache_nway_controller

Parametrised N-way set-associative, write-through, word-granular cache controller between the CPU load/store port and the SRAM main-memory controller. Successor to the fixed 2-way controller. Adds generic WAYS/SETS/address width, true LRU via per-way age counters, invalid-way-first victim choice, a single-cycle flush, and split unidirectional data buses.

## Interface
- ADDR_W, 17: word address width.
- DATA_W, 32: data word width.
- WAYS, 8: associativity; power of two, ≥2.
- SETS, 64: number of sets; power of two, ≥2. SET_W = log2(SETS), TAG_W = ADDR_W − SET_W, AGE_W = log2(WAYS).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_cpu  in  ADDR_W  CPU word address.
- wdata_cpu  in  DATA_W  CPU store data.
- rd_cpu  in  1  load request.
- wr_cpu  in  1  store request.
- flush  in  1  invalidate entire cache.
- rdata_cpu  out  DATA_W  load data, registered.
- rvalid_cpu  out  1  one-cycle pulse; rdata_cpu valid.
- stall_cpu  out  1  controller busy.
- addr_sram  out  ADDR_W  memory address.
- wdata_sram  out  DATA_W  memory write data.
- rdata_sram  in  DATA_W  memory read data.
- rd_sram  out  1  memory read request.
- wr_sram  out  1  memory write request.
- ready_sram  in  1  memory acknowledge.

## Operation
- Address split: set = addr[SET_W−1:0], tag = addr[ADDR_W−1:SET_W].
- Per way and set: tag, data, valid bit, AGE_W-bit age.
- Valid bits and ages are flops. Tag and data arrays may be RAM and are never reset.
- Hit on way w: valid[w][set] and tag[w][set] == tag. At most one way hits.
- Request priority in IDLE: flush > rd_cpu > wr_cpu. A request is accepted only in IDLE. Address and write data are latched on acceptance.
- States:
  - IDLE: accept a request. Load or store → LOOKUP. Flush → FLUSH.
  - LOOKUP:
    - Load hit: drive rdata_cpu from the hit way; pulse rvalid_cpu; LRU update; → IDLE.
    - Load miss: → MISS_RD.
    - Store hit: write data into the hit way; LRU update; → WRITE_MM.
    - Store miss: no allocate; → WRITE_MM.
  - MISS_RD: rd_sram=1, addr_sram=latched address. Hold until ready_sram=1 (ack cycle) → FILL.
  - FILL: write rdata_sram (captured on the ack cycle) into the victim way. Set valid; write tag; LRU update. Drive rdata_cpu, pulse rvalid_cpu; → IDLE.
  - WRITE_MM: wr_sram=1, addr_sram and wdata_sram=latched values. Hold until ready_sram=1 → IDLE.
  - FLUSH: clear all valid bits; ages[w] = w for every set; → IDLE.
- Victim: lowest-index invalid way in the set. If none is invalid, the way whose age = WAYS−1.
- LRU update on access to way h: every way with age < age[h] increments; age[h] ← 0; others unchanged. Ages per set stay a permutation of 0..WAYS−1.
- stall_cpu = (state ≠ IDLE), combinational from the state register.

## Timing
- Reset values:
  - state=IDLE.
  - Outputs: rdata_cpu=0, rvalid_cpu=0, stall_cpu=0, addr_sram=0, wdata_sram=0, rd_sram=0, wr_sram=0.
  - All valid bits 0; ages[w]=w in every set.
- Reset asserted in any state aborts the operation next edge: rd_sram/wr_sram drop, no array write.
- Load hit: request sampled at edge 0, LOOKUP at edge 1, rvalid_cpu high cycle after edge 1. Total 2 cycles; stall_cpu high 1 cycle.
- Load miss: 2 + (cycles in MISS_RD until ack) + 1 FILL cycle. rvalid_cpu pulses the cycle after FILL is left.
- Store: LOOKUP 1 cycle, then WRITE_MM until ack. Array update happens in LOOKUP, before the memory write completes.
- rd_sram/wr_sram are registered and rise on entry to MISS_RD/WRITE_MM. They fall on the edge after ack; never both high.
- ready_sram is ignored outside MISS_RD/WRITE_MM.
- Flush takes 1 cycle in FLUSH; stall_cpu high that cycle.
- Requests asserted while stall_cpu=1 are ignored; the CPU must re-present them.
- rd_cpu and wr_cpu together: load only.

## Test plan
- Reset, then load addr 0x00040 with memory returning 0xDEADBEEF after 3 wait cycles → rd_sram high 4 cycles, rvalid_cpu with 0xDEADBEEF. A second load of the same address hits: 2 cycles, no rd_sram.
- WAYS=8: fill set 0 with tags 0..7, then reload tag 0, then miss on tag 8 → tag 1 (age 7) is evicted. A reload of tag 1 misses; tag 0 hits.
- Store 0x12345678 to a cached address → wr_sram with addr/data matching. A subsequent load hits and returns 0x12345678.
- Store to an uncached address → wr_sram issued, no allocate. A subsequent load misses.
- flush after filling ≥3 sets → every subsequent load misses. rd_cpu asserted the same cycle as flush is ignored.
- reset asserted mid MISS_RD → rd_sram=0 next cycle, state IDLE, and a subsequent load of that address misses.

Source files
------------

// File: rtl/cache_nway_controller.sv
// N-way set-associative write-through cache controller with true LRU ages,
// invalid-way-first victim choice, single-cycle flush and a simple SRAM handshake.
module cache_nway_controller #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int WAYS   = 8,
  parameter int SETS   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic [DATA_W-1:0] wdata_cpu,
  input  logic              rd_cpu,
  input  logic              wr_cpu,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata_cpu,
  output logic              rvalid_cpu,
  output logic              stall_cpu,
  output logic [ADDR_W-1:0] addr_sram,
  output logic [DATA_W-1:0] wdata_sram,
  input  logic [DATA_W-1:0] rdata_sram,
  output logic              rd_sram,
  output logic              wr_sram,
  input  logic              ready_sram
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - SET_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_RD,
    FILL,
    WRITE_MM,
    FLUSH
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic              load_q;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS];
  logic              valid    [WAYS][SETS];
  logic [AGE_W-1:0]  age      [WAYS][SETS];

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag_idx;
  logic              hit_any;
  logic [AGE_W-1:0]  hit_way;
  logic [AGE_W-1:0]  victim;
  logic              found_invalid;

  logic              accept;
  logic              array_wr;
  logic              alloc;
  logic [AGE_W-1:0]  wr_way;
  logic [DATA_W-1:0] wr_data;
  logic              lru_en;
  logic [AGE_W-1:0]  lru_way;
  logic              flush_all;

  logic [DATA_W-1:0] nxt_rdata;
  logic              nxt_rvalid;
  logic              nxt_rd_sram;
  logic              nxt_wr_sram;
  logic [ADDR_W-1:0] nxt_addr_sram;
  logic [DATA_W-1:0] nxt_wdata_sram;
  logic [DATA_W-1:0] nxt_fill;

  assign set_idx   = addr_q[SET_W-1:0];
  assign tag_idx   = addr_q[ADDR_W-1:SET_W];
  assign stall_cpu = (state != IDLE);

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][set_idx] && (tag_mem[w][set_idx] == tag_idx)) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Prefer the lowest invalid way; otherwise evict the oldest (age WAYS-1).
  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid[w][set_idx]) begin
        victim        = AGE_W'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w][set_idx] == AGE_W'(WAYS - 1)) begin
          victim = AGE_W'(w);
        end
      end
    end
  end

  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    array_wr       = 1'b0;
    alloc          = 1'b0;
    wr_way         = hit_way;
    wr_data        = wdata_q;
    lru_en         = 1'b0;
    lru_way        = hit_way;
    flush_all      = 1'b0;
    nxt_rdata      = rdata_cpu;
    nxt_rvalid     = 1'b0;
    nxt_rd_sram    = rd_sram;
    nxt_wr_sram    = wr_sram;
    nxt_addr_sram  = addr_sram;
    nxt_wdata_sram = wdata_sram;
    nxt_fill       = fill_q;
    case (state)
      IDLE: begin
        if (flush) begin
          next_state = FLUSH;
        end else if (rd_cpu || wr_cpu) begin
          accept     = 1'b1;
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        if (load_q) begin
          if (hit_any) begin
            nxt_rdata  = data_mem[hit_way][set_idx];
            nxt_rvalid = 1'b1;
            lru_en     = 1'b1;
            next_state = IDLE;
          end else begin
            nxt_rd_sram   = 1'b1;
            nxt_addr_sram = addr_q;
            next_state    = MISS_RD;
          end
        end else begin
          // Write-through without allocate: only an existing line is updated.
          if (hit_any) begin
            array_wr = 1'b1;
            lru_en   = 1'b1;
          end
          nxt_wr_sram    = 1'b1;
          nxt_addr_sram  = addr_q;
          nxt_wdata_sram = wdata_q;
          next_state     = WRITE_MM;
        end
      end
      MISS_RD: begin
        if (ready_sram) begin
          nxt_fill    = rdata_sram;
          nxt_rd_sram = 1'b0;
          next_state  = FILL;
        end
      end
      FILL: begin
        array_wr   = 1'b1;
        alloc      = 1'b1;
        wr_way     = victim;
        wr_data    = fill_q;
        lru_en     = 1'b1;
        lru_way    = victim;
        nxt_rdata  = fill_q;
        nxt_rvalid = 1'b1;
        next_state = IDLE;
      end
      WRITE_MM: begin
        if (ready_sram) begin
          nxt_wr_sram = 1'b0;
          next_state  = IDLE;
        end
      end
      FLUSH: begin
        flush_all  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdata_cpu  <= '0;
      rvalid_cpu <= 1'b0;
      rd_sram    <= 1'b0;
      wr_sram    <= 1'b0;
      addr_sram  <= '0;
      wdata_sram <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      load_q     <= 1'b0;
    end else begin
      state      <= next_state;
      rdata_cpu  <= nxt_rdata;
      rvalid_cpu <= nxt_rvalid;
      rd_sram    <= nxt_rd_sram;
      wr_sram    <= nxt_wr_sram;
      addr_sram  <= nxt_addr_sram;
      wdata_sram <= nxt_wdata_sram;
      fill_q     <= nxt_fill;
      if (accept) begin
        addr_q  <= addr_cpu;
        wdata_q <= wdata_cpu;
        load_q  <= rd_cpu;
      end
    end
  end

  // Ages stay a permutation: ways younger than the touched one each grow older by one.
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
          age[w][s]   <= AGE_W'(w);
        end
      end
    end else begin
      if (alloc) begin
        valid[wr_way][set_idx] <= 1'b1;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age[w][set_idx] < age[lru_way][set_idx]) begin
            age[w][set_idx] <= age[w][set_idx] + AGE_W'(1);
          end
        end
        age[lru_way][set_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && array_wr) begin
      data_mem[wr_way][set_idx] <= wr_data;
      if (alloc) begin
        tag_mem[wr_way][set_idx] <= tag_idx;
      end
    end
  end

endmodule

// File: tb/tb_cache_nway_controller.sv
// Table-driven bench for cache_nway_controller: directed load/store/flush vectors
// with hand-computed latencies and data, plus a reset-during-miss sequence.
module tb_cache_nway_controller;

  localparam int OP_LOAD  = 0;
  localparam int OP_STORE = 1;
  localparam int OP_FLUSH = 2;
  localparam int OP_BOTH  = 3;

  typedef struct {
    int          op;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          waits;
    int          expStall;
    int          expRd;
    int          expWr;
    int          expRvalid;
    logic [31:0] expRdata;
    int          rst;
  } vec_t;

  typedef struct {
    int          stall;
    int          sawRd;
    int          sawWr;
    int          rvalid;
    int          both;
    int          done;
    logic [31:0] rdata;
    logic [16:0] sramAddr;
    logic [31:0] sramWdata;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [16:0] addr_cpu;
  logic [31:0] wdata_cpu;
  logic        rd_cpu;
  logic        wr_cpu;
  logic        flush;
  logic [31:0] rdata_cpu;
  logic        rvalid_cpu;
  logic        stall_cpu;
  logic [16:0] addr_sram;
  logic [31:0] wdata_sram;
  logic [31:0] rdata_sram;
  logic        rd_sram;
  logic        wr_sram;
  logic        ready_sram;

  int checks;
  int errors;
  vec_t vecs[$];

  cache_nway_controller dut (
    .clk        (clk),
    .reset      (reset),
    .addr_cpu   (addr_cpu),
    .wdata_cpu  (wdata_cpu),
    .rd_cpu     (rd_cpu),
    .wr_cpu     (wr_cpu),
    .flush      (flush),
    .rdata_cpu  (rdata_cpu),
    .rvalid_cpu (rvalid_cpu),
    .stall_cpu  (stall_cpu),
    .addr_sram  (addr_sram),
    .wdata_sram (wdata_sram),
    .rdata_sram (rdata_sram),
    .rd_sram    (rd_sram),
    .wr_sram    (wr_sram),
    .ready_sram (ready_sram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkv(input int op, input logic [16:0] addr, input logic [31:0] wdata,
                               input logic [31:0] memData, input int waits, input int expStall,
                               input int expRd, input int expWr, input int expRvalid,
                               input logic [31:0] expRdata, input int rst);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.memData = memData; v.waits = waits;
    v.expStall = expStall; v.expRd = expRd; v.expWr = expWr; v.expRvalid = expRvalid;
    v.expRdata = expRdata; v.rst = rst;
    return v;
  endfunction

  task automatic resetDut();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one request, then play the SRAM side until the controller returns to idle.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    int rdCnt;
    int wrCnt;
    rdCnt = 0;
    wrCnt = 0;
    o = '{default: 0};
    @(negedge clk);
    addr_cpu  = v.addr;
    wdata_cpu = v.wdata;
    rd_cpu    = (v.op == OP_LOAD || v.op == OP_BOTH || v.op == OP_FLUSH);
    wr_cpu    = (v.op == OP_STORE || v.op == OP_BOTH);
    flush     = (v.op == OP_FLUSH);
    @(negedge clk);
    rd_cpu = 1'b0;
    wr_cpu = 1'b0;
    flush  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rvalid_cpu) begin
        o.rvalid = 1;
        o.rdata  = rdata_cpu;
      end
      if (rd_sram && wr_sram) o.both = 1;
      if (!stall_cpu) begin
        o.done = 1;
        break;
      end
      o.stall++;
      ready_sram = 1'b0;
      rdata_sram = 32'hBAD0BAD0;
      if (rd_sram) begin
        o.sawRd    = 1;
        o.sramAddr = addr_sram;
        rdCnt++;
        if (rdCnt == v.waits + 1) begin
          ready_sram = 1'b1;
          rdata_sram = v.memData;
        end
      end
      if (wr_sram) begin
        o.sawWr     = 1;
        o.sramAddr  = addr_sram;
        o.sramWdata = wdata_sram;
        wrCnt++;
        if (wrCnt == v.waits + 1) ready_sram = 1'b1;
      end
      @(negedge clk);
    end
    ready_sram = 1'b0;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    obs_t o;
    string tag;
    if (v.rst != 0) resetDut();
    applyStimulus(v, o);
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, "_done"}, o.done, 1);
    checkOutput({tag, "_stall_cycles"}, o.stall, v.expStall);
    checkOutput({tag, "_rd_sram"}, o.sawRd, v.expRd);
    checkOutput({tag, "_wr_sram"}, o.sawWr, v.expWr);
    checkOutput({tag, "_rvalid"}, o.rvalid, v.expRvalid);
    checkOutput({tag, "_rd_wr_overlap"}, o.both, 0);
    if (v.expRvalid != 0) checkOutput({tag, "_rdata"}, o.rdata, v.expRdata);
    if (v.expRd != 0 || v.expWr != 0) checkOutput({tag, "_addr_sram"}, {15'd0, o.sramAddr}, {15'd0, v.addr});
    if (v.expWr != 0) checkOutput({tag, "_wdata_sram"}, o.sramWdata, v.wdata);
  endtask

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    reset = 1'b1; addr_cpu = '0; wdata_cpu = '0; rd_cpu = 1'b0; wr_cpu = 1'b0;
    flush = 1'b0; rdata_sram = '0; ready_sram = 1'b0;

    // Basic miss/hit and write-through behaviour.
    vecs.push_back(mkv(OP_LOAD,  17'h00040, 0, 32'hDEADBEEF, 3, 6, 1, 0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00040, 0, 32'h0,        0, 1, 0, 0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mkv(OP_STORE, 17'h00040, 32'h12345678, 0, 1, 3, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00040, 0, 32'h0,        0, 1, 0, 0, 1, 32'h12345678, 0));
    vecs.push_back(mkv(OP_STORE, 17'h00123, 32'hCAFEF00D, 0, 0, 2, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00123, 0, 32'h11112222, 0, 3, 1, 0, 1, 32'h11112222, 0));
    // LRU: fill set 0 with tags 0..7 after a fresh reset.
    for (int t = 0; t < 8; t++) begin
      vecs.push_back(mkv(OP_LOAD, 17'(t * 64), 0, 32'hA0000000 + t, 0, 3, 1, 0, 1,
                         32'hA0000000 + t, (t == 0) ? 1 : 0));
    end
    vecs.push_back(mkv(OP_LOAD, 17'h00000, 0, 32'h0,        0, 1, 0, 0, 1, 32'hA0000000, 0));
    vecs.push_back(mkv(OP_LOAD, 17'h00200, 0, 32'hA0000008, 0, 3, 1, 0, 1, 32'hA0000008, 0));
    vecs.push_back(mkv(OP_LOAD, 17'h00040, 0, 32'hB0000001, 0, 3, 1, 0, 1, 32'hB0000001, 0));
    vecs.push_back(mkv(OP_LOAD, 17'h00000, 0, 32'h0,        0, 1, 0, 0, 1, 32'hA0000000, 0));
    vecs.push_back(mkv(OP_LOAD, 17'h00200, 0, 32'h0,        0, 1, 0, 0, 1, 32'hA0000008, 0));
    // Flush after populating three other sets; the load presented with flush is dropped.
    vecs.push_back(mkv(OP_LOAD,  17'h00001, 0, 32'hC0000001, 1, 4, 1, 0, 1, 32'hC0000001, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00002, 0, 32'hC0000002, 0, 3, 1, 0, 1, 32'hC0000002, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00003, 0, 32'hC0000003, 2, 5, 1, 0, 1, 32'hC0000003, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00001, 0, 32'h0,        0, 1, 0, 0, 1, 32'hC0000001, 0));
    vecs.push_back(mkv(OP_FLUSH, 17'h00001, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00001, 0, 32'hD0000001, 0, 3, 1, 0, 1, 32'hD0000001, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00002, 0, 32'hD0000002, 0, 3, 1, 0, 1, 32'hD0000002, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00003, 0, 32'hD0000003, 0, 3, 1, 0, 1, 32'hD0000003, 0));
    vecs.push_back(mkv(OP_LOAD,  17'h00000, 0, 32'hD0000000, 0, 3, 1, 0, 1, 32'hD0000000, 0));
    // Load and store together behave as a load.
    vecs.push_back(mkv(OP_BOTH,  17'h00001, 32'h55555555, 0, 0, 1, 0, 0, 1, 32'hD0000001, 0));

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_rdata_cpu", rdata_cpu, 32'h0);
    checkOutput("reset_rvalid_cpu", {31'd0, rvalid_cpu}, 32'h0);
    checkOutput("reset_stall_cpu", {31'd0, stall_cpu}, 32'h0);
    checkOutput("reset_addr_sram", {15'd0, addr_sram}, 32'h0);
    checkOutput("reset_wdata_sram", wdata_sram, 32'h0);
    checkOutput("reset_rd_wr_sram", {30'd0, rd_sram, wr_sram}, 32'h0);

    foreach (vecs[i]) runVector(i, vecs[i]);

    // Reset in the middle of a refill aborts it and leaves the line uncached.
    @(negedge clk);
    addr_cpu = 17'h00055;
    rd_cpu   = 1'b1;
    @(negedge clk);
    rd_cpu = 1'b0;
    guard  = 0;
    while (!rd_sram && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("midmiss_rd_sram_seen", {31'd0, rd_sram}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midmiss_rd_sram_drop", {31'd0, rd_sram}, 32'h0);
    checkOutput("midmiss_stall_drop", {31'd0, stall_cpu}, 32'h0);
    checkOutput("midmiss_wr_sram", {31'd0, wr_sram}, 32'h0);
    reset = 1'b0;
    runVector(100, mkv(OP_LOAD, 17'h00055, 0, 32'hE0000055, 0, 3, 1, 0, 1, 32'hE0000055, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
